// File: rtl/parity_checker.sv
// parity_checker: single-entry registered parity check stage with valid/ready handshake.
// Define PARITY_ERR_CNT_EN to add the 8-bit saturating mismatch counter on err_cnt_o.
module parity_checker #(
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [15:0] data_i,
    input  logic        parity_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [15:0] data_o,
    output logic        err_o,
    output logic        err_sticky_o,
    input  logic        clear_i
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt_o
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic ODD_BIT = (ODD_PARITY != 0);

    state_t state;
    logic   mismatch;
    logic   accept;
    logic   acc_err;

    // Ready is combinational so a FULL stage drained this cycle can refill in the same cycle.
    always_comb begin
        mismatch = (^data_i) ^ parity_i ^ ODD_BIT;
        ready_o  = (state == EMPTY) || ready_i;
        accept   = valid_i && ready_o;
        acc_err  = accept && mismatch;
    end

    assign valid_o = (state == FULL);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= EMPTY;
            data_o       <= '0;
            err_o        <= 1'b0;
            err_sticky_o <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
            err_cnt_o    <= '0;
`endif
        end else begin
            if (accept) begin
                state  <= FULL;
                data_o <= data_i;
                err_o  <= mismatch;
            end else if (ready_i) begin
                state <= EMPTY;
            end

            // A mismatch accepted alongside clear_i wins over the clear.
            err_sticky_o <= acc_err || (err_sticky_o && !clear_i);
`ifdef PARITY_ERR_CNT_EN
            if (clear_i) begin
                err_cnt_o <= acc_err ? 8'd1 : 8'd0;
            end else if (acc_err && (err_cnt_o != 8'hFF)) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_parity_checker.sv
// Self-checking bench for parity_checker: even and odd instances share stimulus and are
// compared against a queue-based reference model of the handshake and error rules.
module tb_parity_checker;

    logic        clk;
    logic        rst_ni;
    logic        valid_i;
    logic [15:0] data_i;
    logic        parity_i;
    logic        ready_i;
    logic        clear_i;

    logic        ready_e, valid_e, err_e, sticky_e;
    logic [15:0] data_e;
    logic        ready_d, valid_d, err_d, sticky_d;
    logic [15:0] data_d;
`ifdef PARITY_ERR_CNT_EN
    logic [7:0]  cnt_e, cnt_d;
`endif

    int n_checks = 0;
    int n_errors = 0;

    parity_checker #(.ODD_PARITY(0)) dut_even (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_e),
        .data_i(data_i), .parity_i(parity_i), .valid_o(valid_e), .ready_i(ready_i),
        .data_o(data_e), .err_o(err_e), .err_sticky_o(sticky_e), .clear_i(clear_i)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt_o(cnt_e)
`endif
    );

    parity_checker #(.ODD_PARITY(1)) dut_odd (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_d),
        .data_i(data_i), .parity_i(parity_i), .valid_o(valid_d), .ready_i(ready_i),
        .data_o(data_d), .err_o(err_d), .err_sticky_o(sticky_d), .clear_i(clear_i)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt_o(cnt_d)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed tuple: {valid, data, err (masked when not valid), sticky, ready}
    logic [19:0] got_e, got_d;
    assign got_e = {valid_e, data_e, valid_e & err_e, sticky_e, ready_e};
    assign got_d = {valid_d, data_d, valid_d & err_d, sticky_d, ready_d};

    // Reference model: the held stage is a queue of at most one word.
    typedef struct {
        logic [15:0] d;
        logic        ee;
        logic        eo;
    } word_t;

    word_t       q[$];
    logic [15:0] last_d;
    bit          m_st_e, m_st_o;
    int          m_cnt_e, m_cnt_o;

    always @(posedge clk) begin
        bit rdy, acc, me;
        if (!rst_ni) begin
            q.delete();
            last_d  = 16'h0000;
            m_st_e  = 1'b0;
            m_st_o  = 1'b0;
            m_cnt_e = 0;
            m_cnt_o = 0;
        end else begin
            rdy = (q.size() == 0) || ready_i;
            acc = valid_i && rdy;
            me  = (($countones(data_i) + int'(parity_i)) % 2) == 1;
            if (q.size() != 0 && ready_i) void'(q.pop_front());
            if (acc) begin
                q.push_back('{d: data_i, ee: me, eo: !me});
                last_d = data_i;
            end
            m_st_e = (m_st_e && !clear_i) || (acc && me);
            m_st_o = (m_st_o && !clear_i) || (acc && !me);
            if (clear_i) begin
                m_cnt_e = 0;
                m_cnt_o = 0;
            end
            if (acc && me && m_cnt_e < 255) m_cnt_e++;
            if (acc && !me && m_cnt_o < 255) m_cnt_o++;
        end
    end

    function automatic logic [19:0] exp_t(bit odd);
        logic v;
        logic er;
        v  = (q.size() != 0);
        er = v ? (odd ? q[0].eo : q[0].ee) : 1'b0;
        return {v, v ? q[0].d : last_d, er, odd ? m_st_o : m_st_e, !v || ready_i};
    endfunction

    task automatic drive(input logic v, input logic [15:0] d, input logic p,
                         input logic r, input logic c);
        valid_i  = v;
        data_i   = d;
        parity_i = p;
        ready_i  = r;
        clear_i  = c;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        drive(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (got_e !== 20'h00001) begin
            n_errors++; $display("FAIL reset_even: got=%h exp=%h", got_e, 20'h00001);
        end
        n_checks++;
        if (got_d !== 20'h00001) begin
            n_errors++; $display("FAIL reset_odd: got=%h exp=%h", got_d, 20'h00001);
        end
`ifdef PARITY_ERR_CNT_EN
        n_checks++;
        if (cnt_e !== 8'd0 || cnt_d !== 8'd0) begin
            n_errors++; $display("FAIL reset_cnt: got=%0d/%0d exp=0", cnt_e, cnt_d);
        end
`endif
        rst_ni = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_directed;
        drive(1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({valid_e, data_e, err_e} !== {1'b1, 16'h0001, 1'b0}) begin
            n_errors++; $display("FAIL even_ok: got=%b/%h/%b exp=1/0001/0", valid_e, data_e, err_e);
        end
        n_checks++;
        if (err_d !== 1'b1) begin
            n_errors++; $display("FAIL odd_0001: got err=%b exp=1", err_d);
        end
        drive(1'b1, 16'h0003, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({err_e, sticky_e} !== 2'b11) begin
            n_errors++; $display("FAIL even_err: got err=%b sticky=%b exp=1/1", err_e, sticky_e);
        end
        drive(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({valid_d, err_d} !== 2'b10) begin
            n_errors++; $display("FAIL odd_ok: got valid=%b err=%b exp=1/0", valid_d, err_d);
        end
        drive(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (err_d !== 1'b1) begin
            n_errors++; $display("FAIL odd_err: got err=%b exp=1", err_d);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (got_e !== exp_t(0) || valid_e !== 1'b0) begin
            n_errors++; $display("FAIL drain: got=%h exp=%h", got_e, exp_t(0));
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] sent[$];
        logic [15:0] d;
        for (int i = 0; i < 100; i++) begin
            d = 16'($urandom);
            sent.push_back(d);
            drive(1'b1, d, 1'($urandom), 1'b1, 1'b0);
            #1;
            n_checks++;
            if (ready_e !== 1'b1 || ready_d !== 1'b1) begin
                n_errors++; $display("FAIL stream_ready[%0d]: got=%b/%b exp=1", i, ready_e, ready_d);
            end
            @(negedge clk);
            n_checks++;
            if (valid_e !== 1'b1 || data_e !== sent[i]) begin
                n_errors++; $display("FAIL stream_order[%0d]: got=%b/%h exp=1/%h", i, valid_e, data_e, sent[i]);
            end
            n_checks++;
            if (got_e !== exp_t(0) || got_d !== exp_t(1)) begin
                n_errors++; $display("FAIL stream_model[%0d]: got=%h/%h exp=%h/%h", i, got_e, got_d, exp_t(0), exp_t(1));
            end
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        drive(1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (ready_e !== 1'b0 || ready_d !== 1'b0) begin
                n_errors++; $display("FAIL bp_ready[%0d]: got=%b/%b exp=0", i, ready_e, ready_d);
            end
            @(negedge clk);
            n_checks++;
            if (valid_e !== 1'b1 || data_e !== 16'hA5A5 || got_e !== exp_t(0)) begin
                n_errors++; $display("FAIL bp_hold[%0d]: got=%h exp data=a5a5 tuple=%h", i, got_e, exp_t(0));
            end
        end
        ready_i = 1'b1;
        #1;
        n_checks++;
        if (ready_e !== 1'b1) begin
            n_errors++; $display("FAIL bp_release_ready: got=%b exp=1", ready_e);
        end
        @(negedge clk);
        n_checks++;
        if (valid_e !== 1'b1 || data_e !== 16'h1234 || got_d !== exp_t(1)) begin
            n_errors++; $display("FAIL bp_next: got=%b/%h exp=1/1234", valid_e, data_e);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (valid_e !== 1'b0) begin
            n_errors++; $display("FAIL bp_drain: got valid=%b exp=0", valid_e);
        end
    endtask

    task automatic test_saturation;
        logic [15:0] d;
        for (int i = 0; i < 300; i++) begin
            d = 16'($urandom);
            drive(1'b1, d, ~(^d), 1'b1, 1'b0);
            @(negedge clk);
            n_checks++;
            if (got_e !== exp_t(0) || got_d !== exp_t(1)) begin
                n_errors++; $display("FAIL sat_model[%0d]: got=%h/%h exp=%h/%h", i, got_e, got_d, exp_t(0), exp_t(1));
            end
        end
        n_checks++;
        if (sticky_e !== 1'b1) begin
            n_errors++; $display("FAIL sat_sticky: got=%b exp=1", sticky_e);
        end
`ifdef PARITY_ERR_CNT_EN
        n_checks++;
        if (cnt_e !== 8'd255 || cnt_d !== 8'(m_cnt_o)) begin
            n_errors++; $display("FAIL sat_cnt: got=%0d/%0d exp=255/%0d", cnt_e, cnt_d, m_cnt_o);
        end
`endif
        d = 16'h00F1;
        drive(1'b1, d, ~(^d), 1'b1, 1'b1);
        @(negedge clk);
        n_checks++;
        if (sticky_e !== 1'b1 || got_d !== exp_t(1)) begin
            n_errors++; $display("FAIL clear_vs_err: got sticky=%b odd=%h exp=1 odd=%h", sticky_e, got_d, exp_t(1));
        end
`ifdef PARITY_ERR_CNT_EN
        n_checks++;
        if (cnt_e !== 8'd1 || cnt_d !== 8'd0) begin
            n_errors++; $display("FAIL clear_vs_err_cnt: got=%0d/%0d exp=1/0", cnt_e, cnt_d);
        end
`endif
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (sticky_e !== 1'b0 || got_e !== exp_t(0)) begin
            n_errors++; $display("FAIL clear_only: got=%h exp=%h", got_e, exp_t(0));
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            @(negedge clk);
            n_checks++;
            if (got_e !== exp_t(0) || got_d !== exp_t(1)) begin
                n_errors++; $display("FAIL rand_model[%0d]: got=%h/%h exp=%h/%h", i, got_e, got_d, exp_t(0), exp_t(1));
            end
`ifdef PARITY_ERR_CNT_EN
            n_checks++;
            if (cnt_e !== 8'(m_cnt_e) || cnt_d !== 8'(m_cnt_o)) begin
                n_errors++; $display("FAIL rand_cnt[%0d]: got=%0d/%0d exp=%0d/%0d", i, cnt_e, cnt_d, m_cnt_e, m_cnt_o);
            end
`endif
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        for (int i = 0; i < 7; i++) begin
            d = 16'h1000 + 16'(i);
            drive(1'b1, d, ~(^d), 1'b1, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({valid_e, sticky_e, data_e} !== {2'b11, 16'h1006}) begin
            n_errors++; $display("FAIL pre_reset: got=%b/%b/%h exp=1/1/1006", valid_e, sticky_e, data_e);
        end
`ifdef PARITY_ERR_CNT_EN
        n_checks++;
        if (cnt_e !== 8'd7) begin
            n_errors++; $display("FAIL pre_reset_cnt: got=%0d exp=7", cnt_e);
        end
`endif
        rst_ni = 1'b0;
        drive(1'b1, 16'h5555, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (got_e !== 20'h00001 || got_d !== 20'h00001) begin
            n_errors++; $display("FAIL mid_reset: got=%h/%h exp=00001", got_e, got_d);
        end
`ifdef PARITY_ERR_CNT_EN
        n_checks++;
        if (cnt_e !== 8'd0) begin
            n_errors++; $display("FAIL mid_reset_cnt: got=%0d exp=0", cnt_e);
        end
`endif
        rst_ni = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (valid_e !== 1'b0 || got_e !== exp_t(0)) begin
            n_errors++; $display("FAIL post_reset: got=%h exp=%h", got_e, exp_t(0));
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/parity_checker.md
PARITY_CHECKER -- requirements
Module: parity_checker

Interface
REQ-001 Parameter ODD_PARITY, default 0, 0 = even parity (parity bit equals XOR of data bits), 1 = odd parity (parity bit equals inverted XOR).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 valid_i  input  1  upstream word + parity present.
REQ-005 ready_o  output  1  block can accept a word this cycle.
REQ-006 data_i  input  16  received data word.
REQ-007 parity_i  input  1  received parity bit from the generator stage.
REQ-008 valid_o  output  1  checked word held on outputs.
REQ-009 ready_i  input  1  downstream accepts the held word.
REQ-010 data_o  output  16  registered copy of accepted data_i.
REQ-011 err_o  output  1  parity mismatch flag for the held word; meaningful only while valid_o=1.
REQ-012 err_sticky_o  output  1  set by any accepted mismatched word; held until cleared.
REQ-013 clear_i  input  1  synchronous clear of err_sticky_o and err_cnt_o.
REQ-014 err_cnt_o  output  8  saturating count of accepted mismatched words; present only with PARITY_ERR_CNT_EN.

Function
REQ-015 Mismatch = (XOR of data_i[15:0]) XOR parity_i XOR ODD_PARITY; combinational, evaluated on the input word.
REQ-016 Two states, EMPTY (valid_o=0) and FULL (valid_o=1).
REQ-017 ready_o = (state==EMPTY) OR ready_i; combinational, no registered-ready bubble.
REQ-018 Accept = valid_i AND ready_o; on accept: data_o<=data_i, err_o<=mismatch, state<=FULL.
REQ-019 FULL with ready_i=1 and no accept -> EMPTY; FULL with ready_i=1 and accept -> remains FULL with new word (back-to-back, 1 word/cycle).
REQ-020 FULL with ready_i=0: data_o, err_o, valid_o held stable; valid_i ignored (ready_o=0).
REQ-021 Latency: word accepted in cycle N appears on valid_o/data_o/err_o in cycle N+1.
REQ-022 No word is dropped or duplicated; each accepted word presented exactly once until ready_i=1.
REQ-023 err_sticky_o: set on accept with mismatch; cleared by clear_i; simultaneous clear_i and accepted mismatch -> set wins (stays 1).
REQ-024 err_cnt_o: +1 on accept with mismatch; saturates at 255 (no wrap); clear_i -> 0; simultaneous clear_i and accepted mismatch -> 1.
REQ-025 clear_i does not affect valid_o, data_o, err_o or the handshake.
REQ-026 valid_i with unknown/changing data while ready_o=0 has no effect on state.

Reset
REQ-027 rst_ni=0 at a rising edge: state=EMPTY, valid_o=0, data_o=16'h0000, err_o=0, err_sticky_o=0, err_cnt_o=0.
REQ-028 ready_o=1 during and immediately after reset (follows REQ-017).
REQ-029 Reset mid-transfer discards the held word; no output handshake completes for it.
REQ-030 Reset has priority over accept and clear_i in the same cycle.

Configuration
REQ-031 Macro PARITY_ERR_CNT_EN defined: err_cnt_o port and 8-bit saturating counter present per REQ-024.
REQ-032 PARITY_ERR_CNT_EN undefined: err_cnt_o port and counter absent; all other behaviour identical.

Verification
REQ-033 Even mode: data_i=16'h0001, parity_i=1, valid_i=1, ready_i=1 -> next cycle valid_o=1, data_o=16'h0001, err_o=0; data_i=16'h0003, parity_i=1 -> err_o=1, err_sticky_o=1.
REQ-034 ODD_PARITY=1: data_i=16'hFFFF, parity_i=1 -> err_o=0; parity_i=0 -> err_o=1.
REQ-035 Backpressure: accept 16'hA5A5, hold ready_i=0 for 5 cycles while valid_i=1 with 16'h1234 -> ready_o=0, data_o stays 16'hA5A5; ready_i=1 -> 16'h1234 taken same cycle, presented next cycle.
REQ-036 Streaming: 100 back-to-back words, ready_i=1 always -> 100 outputs in order, one per cycle, ready_o constantly 1.
REQ-037 PARITY_ERR_CNT_EN: 300 mismatched words -> err_cnt_o=255; clear_i asserted with a mismatched accept -> err_cnt_o=1, err_sticky_o=1.
REQ-038 rst_ni=0 while FULL with err_sticky_o=1, err_cnt_o=7 -> next cycle valid_o=0, data_o=0, err_sticky_o=0, err_cnt_o=0, ready_o=1.
